// File: rtl/range_sum_pkg.sv
// Shared types and constants for the range_sum_acc engine.
package range_sum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_SUM = 1'b0;
  localparam logic MODE_SQR = 1'b1;

endpackage

// File: rtl/range_sum_term.sv
// Combinational series term: x or x*x, zero-extended to 2*DATA_W bits.
// Kept separate so the multiplier can be replaced by a pipelined one.
module range_sum_term
  import range_sum_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0]   i_cur,
  input  logic                i_mode,
  output logic [2*DATA_W-1:0] o_term
);

  always_comb begin
    o_term = (2*DATA_W)'(i_cur);
    if (i_mode == MODE_SQR) begin
      o_term = (2*DATA_W)'(i_cur) * (2*DATA_W)'(i_cur);
    end
  end

endmodule

// File: rtl/range_sum_acc.sv
// Multi-cycle accumulator for lo, lo+step, ... <= hi (plain or squared terms),
// one term per clock, behind a start/done handshake with abort and sticky overflow.
module range_sum_acc
  import range_sum_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] lo,
  input  logic [DATA_W-1:0] hi,
  input  logic [DATA_W-1:0] step,
  input  logic              mode,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  sum_out,
  output logic              overflow,
  output logic              err
);

  localparam int TERM_W = 2 * DATA_W;
  localparam int SUM_W  = ((ACC_W > TERM_W) ? ACC_W : TERM_W) + 1;

  generate
    if (ACC_W < DATA_W) begin : g_cfg_check
      $error("range_sum_acc: ACC_W must be >= DATA_W");
    end
  endgenerate

  // Any bit at or above ACC_W means the add carried out or the term alone was too wide.
  function automatic logic wraps(input logic [SUM_W-1:0] s);
    return |s[SUM_W-1:ACC_W];
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_cur;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_step;
  logic                r_mode;
  logic [ACC_W-1:0]    r_acc;
  logic                r_ovf;
  logic [ACC_W-1:0]    r_sum;
  logic                r_ovf_out;
  logic                r_err;

  logic [TERM_W-1:0]   w_term;
  logic [SUM_W-1:0]    w_sum;
  logic                w_ovf_nxt;
  logic [DATA_W:0]     w_nxt;
  logic                w_last;
  logic                w_invalid;
  logic                w_accept;
  logic                w_run_step;

  range_sum_term #(.DATA_W(DATA_W)) u_term (
    .i_cur  (r_cur),
    .i_mode (r_mode),
    .o_term (w_term)
  );

  assign w_invalid  = (step == '0) || (lo > hi);
  assign w_accept   = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_run_step = (r_state == RUN) && !abort;
  assign w_sum      = SUM_W'(r_acc) + SUM_W'(w_term);
  assign w_ovf_nxt  = r_ovf | wraps(w_sum);
  assign w_nxt      = {1'b0, r_cur} + {1'b0, r_step};
  assign w_last     = (w_nxt > {1'b0, r_hi});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: begin
        w_state_nxt = IDLE;
        if (start) begin
          w_state_nxt = w_invalid ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur     <= '0;
      r_hi      <= '0;
      r_step    <= '0;
      r_mode    <= MODE_SUM;
      r_acc     <= '0;
      r_ovf     <= 1'b0;
      r_sum     <= '0;
      r_ovf_out <= 1'b0;
      r_err     <= 1'b0;
    end else if (w_accept) begin
      if (w_invalid) begin
        r_sum     <= '0;
        r_ovf_out <= 1'b0;
        r_err     <= 1'b1;
      end else begin
        r_cur  <= lo;
        r_hi   <= hi;
        r_step <= step;
        r_mode <= mode;
        r_acc  <= '0;
        r_ovf  <= 1'b0;
      end
    end else if (w_run_step) begin
      r_acc <= w_sum[ACC_W-1:0];
      r_ovf <= w_ovf_nxt;
      if (w_last) begin
        r_sum     <= w_sum[ACC_W-1:0];
        r_ovf_out <= w_ovf_nxt;
        r_err     <= 1'b0;
      end else begin
        r_cur <= w_nxt[DATA_W-1:0];
      end
    end
  end

  assign busy     = (r_state == RUN);
  assign done     = (r_state == DONE);
  assign sum_out  = r_sum;
  assign overflow = r_ovf_out;
  assign err      = r_err;

endmodule

// File: tb/tb_range_sum_acc.sv
// Self-checking bench for range_sum_acc: vector table plus handshake corner sequences.
module tb_range_sum_acc;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] step;
  logic              mode;
  logic              abort;
  logic              busy;
  logic              done;
  logic [ACC_W-1:0]  sum_out;
  logic              overflow;
  logic              err;

  always #5 clk = ~clk;

  range_sum_acc #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .lo       (lo),
    .hi       (hi),
    .step     (step),
    .mode     (mode),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .sum_out  (sum_out),
    .overflow (overflow),
    .err      (err)
  );

  typedef struct {
    logic [DATA_W-1:0] lo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] step;
    logic              mode;
    logic [ACC_W-1:0]  sum;
    logic              ovf;
    logic              err;
    int                n;
  } vec_t;

  typedef struct {
    logic [ACC_W-1:0] sum;
    logic             ovf;
    logic             err;
    int               n;
  } exp_t;

  localparam int NVEC = 13;
  vec_t vecs[NVEC];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Caller is 1ns after an edge; returns 1ns after the edge that sampled start.
  task automatic drive_start(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] h,
                             input logic [DATA_W-1:0] s, input logic m);
    start = 1'b1;
    lo    = l;
    hi    = h;
    step  = s;
    mode  = m;
    tick();
    start = 1'b0;
  endtask

  task automatic request(input string name, input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] h,
                         input logic [DATA_W-1:0] s, input logic m, input logic [ACC_W-1:0] es,
                         input logic eo, input logic ee, input int en);
    exp_t e;
    e.sum = es;
    e.ovf = eo;
    e.err = ee;
    e.n   = en;
    sb.push_back(e);
    drive_start(l, h, s, m);
    check({name, "_busy_after_start"}, 64'(busy), 64'(en > 0));
  endtask

  task automatic wait_done(input string name, input int offset);
    exp_t e;
    int   cycles;
    cycles = offset;
    while (!done && cycles < 600) begin
      tick();
      cycles++;
    end
    if (sb.size() == 0) begin
      check({name, "_scoreboard_empty"}, 64'(0), 64'(1));
    end else begin
      e = sb.pop_front();
      if (!done) begin
        check({name, "_done_timeout"}, 64'(0), 64'(1));
      end else begin
        check({name, "_latency"}, 64'(cycles), 64'(e.n));
        check({name, "_sum"}, 64'(sum_out), 64'(e.sum));
        check({name, "_ovf"}, 64'(overflow), 64'(e.ovf));
        check({name, "_err"}, 64'(err), 64'(e.err));
        check({name, "_busy_in_done"}, 64'(busy), 64'(0));
      end
    end
  endtask

  task automatic expect_no_done(input string name, input int ncyc);
    int seen;
    seen = 0;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      if (done) seen++;
    end
    check({name, "_no_done"}, 64'(seen), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{8'd1,   8'd10,  8'd1,   1'b0, 16'd55,    1'b0, 1'b0, 10};
    vecs[1]  = '{8'd1,   8'd10,  8'd1,   1'b1, 16'd385,   1'b0, 1'b0, 10};
    vecs[2]  = '{8'd250, 8'd255, 8'd3,   1'b0, 16'd503,   1'b0, 1'b0, 2};
    vecs[3]  = '{8'd1,   8'd255, 8'd1,   1'b1, 16'd54656, 1'b1, 1'b0, 255};
    vecs[4]  = '{8'd3,   8'd9,   8'd0,   1'b0, 16'd0,     1'b0, 1'b1, 0};
    vecs[5]  = '{8'd9,   8'd3,   8'd1,   1'b0, 16'd0,     1'b0, 1'b1, 0};
    vecs[6]  = '{8'd7,   8'd7,   8'd1,   1'b1, 16'd49,    1'b0, 1'b0, 1};
    vecs[7]  = '{8'd0,   8'd255, 8'd255, 1'b0, 16'd255,   1'b0, 1'b0, 2};
    vecs[8]  = '{8'd200, 8'd255, 8'd1,   1'b0, 16'd12740, 1'b0, 1'b0, 56};
    vecs[9]  = '{8'd255, 8'd255, 8'd1,   1'b1, 16'd65025, 1'b0, 1'b0, 1};
    vecs[10] = '{8'd254, 8'd255, 8'd1,   1'b1, 16'd64005, 1'b1, 1'b0, 2};
    vecs[11] = '{8'd0,   8'd0,   8'd5,   1'b0, 16'd0,     1'b0, 1'b0, 1};
    vecs[12] = '{8'd3,   8'd9,   8'd3,   1'b1, 16'd126,   1'b0, 1'b0, 3};

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    lo    = '0;
    hi    = '0;
    step  = '0;
    mode  = 1'b0;
    tick();
    tick();
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_sum", 64'(sum_out), 64'(0));
    check("reset_ovf", 64'(overflow), 64'(0));
    check("reset_err", 64'(err), 64'(0));
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < NVEC; i++) begin
      request($sformatf("vec%0d", i), vecs[i].lo, vecs[i].hi, vecs[i].step, vecs[i].mode,
              vecs[i].sum, vecs[i].ovf, vecs[i].err, vecs[i].n);
      wait_done($sformatf("vec%0d", i), 0);
      tick();
    end

    // start during a run must not disturb the captured operands
    request("ignored_start", 8'd1, 8'd10, 8'd1, 1'b0, 16'd55, 1'b0, 1'b0, 10);
    tick();
    drive_start(8'd2, 8'd4, 8'd1, 1'b1);
    wait_done("ignored_start", 2);
    expect_no_done("ignored_start_after", 5);

    // back-to-back: new start held during the done cycle
    request("b2b_first", 8'd1, 8'd10, 8'd1, 1'b0, 16'd55, 1'b0, 1'b0, 10);
    wait_done("b2b_first", 0);
    request("b2b_second", 8'd2, 8'd6, 8'd2, 1'b0, 16'd12, 1'b0, 1'b0, 3);
    wait_done("b2b_second", 0);
    tick();

    // abort at E+4: busy drops at E+5, no done, result held
    drive_start(8'd1, 8'd10, 8'd1, 1'b0);
    tick();
    tick();
    tick();
    tick();
    check("abort_busy_before", 64'(busy), 64'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy_after", 64'(busy), 64'(0));
    expect_no_done("abort", 15);
    check("abort_sum_held", 64'(sum_out), 64'(12));
    check("abort_err_held", 64'(err), 64'(0));

    // abort outside RUN is ignored, even coincident with start
    abort = 1'b1;
    request("abort_idle", 8'd7, 8'd7, 8'd1, 1'b1, 16'd49, 1'b0, 1'b0, 1);
    abort = 1'b0;
    wait_done("abort_idle", 0);
    tick();

    // asynchronous reset mid-run clears everything immediately
    drive_start(8'd1, 8'd255, 8'd1, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_busy", 64'(busy), 64'(0));
    check("midreset_done", 64'(done), 64'(0));
    check("midreset_sum", 64'(sum_out), 64'(0));
    check("midreset_ovf", 64'(overflow), 64'(0));
    check("midreset_err", 64'(err), 64'(0));
    tick();
    rst_n = 1'b1;
    expect_no_done("after_reset", 20);
    request("post_reset", 8'd3, 8'd9, 8'd3, 1'b1, 16'd126, 1'b0, 1'b0, 3);
    wait_done("post_reset", 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/range_sum_acc.md
# range_sum_acc

Parametrised multi-cycle range accumulator, successor to the fixed 1..10 summing block. Sums the arithmetic series lo, lo+step, … ≤ hi, either as plain terms or as squares, one term per clock, with configurable operand and accumulator widths. Adds error detection, sticky overflow, and abort. Sits as a small compute engine behind a start/done handshake.

## Interface
- DATA_W, 8: width of lo, hi, step and of each series element.
- ACC_W, 16: width of the accumulator and sum_out; elaboration error if ACC_W < DATA_W.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  one-cycle request. Sampled only in IDLE or DONE.
- lo  in  DATA_W  first element, unsigned. Sampled with start.
- hi  in  DATA_W  inclusive upper bound, unsigned. Sampled with start.
- step  in  DATA_W  increment, unsigned. Sampled with start.
- mode  in  1  0 = sum of x; 1 = sum of x². Sampled with start.
- abort  in  1  cancel a run in progress.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; sum_out, overflow and err are valid in this cycle.
- sum_out  out  ACC_W  last completed result. Held until the next completion.
- overflow  out  1  the last result wrapped. Held with sum_out.
- err  out  1  the last request was invalid. Held with sum_out.

## Operation
- FSM states: IDLE, RUN, DONE. All outputs are registered or decoded from the state. busy = (state==RUN); done = (state==DONE).
- Reset value: state=IDLE; busy=0, done=0, sum_out=0, overflow=0, err=0; internal registers cleared.
- IDLE/DONE with start=1 and a valid request: capture operands, set cur=lo, acc=0, ovf=0, then go to RUN.
- A request is invalid when step==0 or lo>hi. In that case go directly to DONE and load sum_out=0, overflow=0, err=1.
- RUN, each cycle:
  - term = cur (mode 0) or cur*cur (mode 1), 2*DATA_W bits, zero-extended.
  - acc += term, modulo 2^ACC_W.
  - ovf is set sticky if the add carries out of ACC_W, or if term ≥ 2^ACC_W.
  - nxt = cur+step, computed in DATA_W+1 bits so it never wraps.
  - If nxt > hi: load sum_out = final acc, overflow = final ovf, err=0, and go to DONE. Otherwise cur = nxt.
- DONE lasts exactly one cycle, then IDLE. A start presented in DONE is accepted: the next state is RUN, or DONE for an invalid request.
- start while busy is ignored; it is neither queued nor able to change the captured operands.
- abort in RUN has priority over completion. It causes RUN→IDLE at the next edge, with no done pulse and sum_out/overflow/err unchanged. abort outside RUN is ignored.
- lo==hi is a single-term run.
- Number of terms N = floor((hi−lo)/step)+1.

## Timing
- Start sampled at edge E (valid request): busy is high after E through E+N; done is high for the one cycle after edge E+N; busy is low in that cycle.
- Invalid request at edge E: done and err are high for the one cycle after E; busy never rises.
- Back-to-back: a start held during the done cycle is sampled at edge E+N+1. No idle gap is required.
- Reset asserted mid-run: all outputs take reset values immediately (asynchronous); no done.
- Throughput: one term per cycle. A run plus its done cycle takes N+1 cycles.

## Structure
- Package range_sum_pkg:
  - state_t enum {IDLE, RUN, DONE}.
  - Constants MODE_SUM=1'b0, MODE_SQR=1'b1.
- Sub-module range_sum_term: combinational; inputs cur and mode, output is the 2*DATA_W term. It isolates the multiplier so it can later be swapped for a pipelined version.
- Top-level: FSM plus operand, accumulator and result registers. Estimated 150–250 lines of RTL.

## Test plan
- lo=1, hi=10, step=1, mode=0 → done in the cycle after E+10; sum_out=55, overflow=0, err=0.
- lo=1, hi=10, step=1, mode=1 → sum_out=385 after 10 terms; then lo=250, hi=255, step=3, mode=0 → terms 250 and 253, sum_out=503, N=2 (exercises nxt beyond 255 without wrap).
- lo=1, hi=255, step=1, mode=1, ACC_W=16 → true sum 5559680; sum_out=54656, overflow=1.
- step=0 → done and err high one cycle after the start edge, sum_out=0. Separately, lo=9, hi=3 → same response. Separately, lo=hi=7, mode=1 → sum_out=49, N=1.
- Start 1..10; assert abort for one cycle at E+4 → busy falls at E+5, no done, sum_out keeps the previous result. A start pulsed at E+2 during a run is ignored.
- Assert start during the done cycle of a 1..10 run with new operands lo=2, hi=6, step=2 → second done in the cycle after edge E'+3 with sum_out=12. Then assert rst_n low mid-run → all outputs are 0 immediately.
